exp_golomb_bit_packer: RTL and testbench

EXP_GOLOMB_BIT_PACKER -- requirements
Module: exp_golomb_bit_packer

---
 rtl/exp_golomb_bit_packer_if.sv | 30 +++
 rtl/exp_golomb_bit_packer.sv | 88 ++++++++
 tb/tb_exp_golomb_bit_packer.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/exp_golomb_bit_packer_if.sv
// Codeword-in / byte-out stream bundle for the Exp-Golomb bit packer,
// plus debug visibility of the packer state and pending-bit count.
interface exp_golomb_bit_packer_if #(
    parameter int CW_W = 16
);
    // Both directions use the same handshake: a transfer happens on a rising
    // clock edge where valid (axiiv/axiov) and ready (axiir/axior) are both 1;
    // the producer holds data stable while valid=1 and ready=0.
    logic            axiiv;
    logic [CW_W-1:0] axiid;
    logic            axiir;
    logic            flush;
    logic            axiov;
    logic [7:0]      axiod;
    logic            axior;
    logic            axiol;
    logic            err;
    logic            dbg_state;
    logic [5:0]      dbg_cnt;

    modport master (
        output axiiv, axiid, flush, axior,
        input  axiir, axiov, axiod, axiol, err, dbg_state, dbg_cnt
    );

    modport slave (
        input  axiiv, axiid, flush, axior,
        output axiir, axiov, axiod, axiol, err, dbg_state, dbg_cnt
    );
endinterface

// File: rtl/exp_golomb_bit_packer.sv
// Packs Exp-Golomb codewords (v = codeNum+1) into an MSB-first byte stream,
// with flush appending a stop bit, zero-padding and marking the last byte.
module exp_golomb_bit_packer #(
    parameter int CW_W = 16
) (
    input logic                  clk,
    input logic                  rst,
    exp_golomb_bit_packer_if.slave bus
);
    localparam int ACC_W = 2 * CW_W + 8;
    localparam int M_W   = $clog2(CW_W);

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    state_t           state;
    logic [ACC_W-1:0] acc;
    logic [5:0]       cnt;
    logic             err_q;

    logic [M_W-1:0]   msb;
    logic [5:0]       len;
    logic [5:0]       lsh;
    logic             hs_in;
    logic             accept_cw;
    logic             accept_zero;
    logic             accept_fl;
    logic             pop;
    logic [5:0]       app_cnt;
    logic [5:0]       pad_cnt;
    logic [ACC_W-1:0] cw_field;
    logic [ACC_W-1:0] stop_field;

    // Index of the most-significant 1 of v; zero input is rejected separately.
    always_comb begin
        msb = '0;
        for (int i = 0; i < CW_W; i++) begin
            if (bus.axiid[i]) msb = i[M_W-1:0];
        end
    end

    assign len = 6'({msb, 1'b1});
    assign lsh = 6'(ACC_W) - len;

    assign bus.axiir = rst && (state == RUN) && (cnt < 6'd8);
    assign bus.axiov = (cnt >= 6'd8);
    assign bus.axiod = acc[ACC_W-1 -: 8];
    assign bus.axiol = (state == FLUSH) && (cnt == 6'd8);
    assign bus.err   = err_q;
    assign bus.dbg_state = state;
    assign bus.dbg_cnt   = cnt;

    assign hs_in       = bus.axiiv && bus.axiir;
    assign accept_cw   = hs_in && (bus.axiid != '0);
    assign accept_zero = hs_in && (bus.axiid == '0);
    assign accept_fl   = bus.flush && bus.axiir;
    assign pop         = bus.axiov && bus.axior;

    // The m leading zeros come for free: v right-aligned in an L-bit field.
    assign cw_field   = ({{(ACC_W-CW_W){1'b0}}, bus.axiid} << lsh) >> cnt;
    assign app_cnt    = cnt + (accept_cw ? len : 6'd0);
    assign stop_field = {1'b1, {(ACC_W-1){1'b0}}} >> app_cnt;
    assign pad_cnt    = (app_cnt + 6'd8) & 6'b111000;

    // Bits below cnt are always zero, so padding needs no explicit masking.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= RUN;
            acc   <= '0;
            cnt   <= '0;
            err_q <= 1'b0;
        end else begin
            err_q <= accept_zero;
            if (pop) begin
                acc <= acc << 8;
                cnt <= cnt - 6'd8;
                if (state == FLUSH && cnt == 6'd8) state <= RUN;
            end else begin
                acc <= acc | (accept_cw ? cw_field : '0)
                           | (accept_fl ? stop_field : '0);
                cnt <= accept_fl ? pad_cnt : app_cnt;
                if (accept_fl) state <= FLUSH;
            end
        end
    end
endmodule

// File: tb/tb_exp_golomb_bit_packer.sv
// Directed bench for exp_golomb_bit_packer: hand-computed byte streams,
// flush/stall/reset corner cases, immediate-assertion checks.
module tb_exp_golomb_bit_packer;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    exp_golomb_bit_packer_if bus ();

    exp_golomb_bit_packer #(.CW_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present a codeword and/or flush at a negedge once ready, hold across one edge.
    task automatic send(input logic [15:0] v, input logic cw, input logic fl, input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.axiir && n < 60) begin
            @(negedge clk);
            n++;
        end
        check({tag, " ready"}, 40'(bus.axiir), 40'd1);
        bus.axiiv = cw;
        bus.axiid = v;
        bus.flush = fl;
        @(negedge clk);
        bus.axiiv = 1'b0;
        bus.axiid = '0;
        bus.flush = 1'b0;
    endtask

    task automatic pop(input logic [7:0] e, input logic last, input string tag);
        int n;
        n = 0;
        while (!bus.axiov && n < 60) begin
            @(negedge clk);
            n++;
        end
        check({tag, " valid"}, 40'(bus.axiov), 40'd1);
        check({tag, " data"}, 40'(bus.axiod), 40'(e));
        check({tag, " last"}, 40'(bus.axiol), 40'(last));
        bus.axior = 1'b1;
        @(negedge clk);
        bus.axior = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b0;
        bus.axiiv = 1'b0;
        bus.axiid = '0;
        bus.flush = 1'b0;
        bus.axior = 1'b0;

        #12;
        check("rst axiov", 40'(bus.axiov), 40'd0);
        check("rst axiod", 40'(bus.axiod), 40'h00);
        check("rst axiol", 40'(bus.axiol), 40'd0);
        check("rst err", 40'(bus.err), 40'd0);
        check("rst axiir", 40'(bus.axiir), 40'd0);
        check("rst cnt", 40'(bus.dbg_cnt), 40'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("release axiir", 40'(bus.axiir), 40'd1);

        // Eight one-bit codewords form a single 0xFF byte
        for (int i = 0; i < 8; i++) send(16'h0001, 1'b1, 1'b0, "ones");
        pop(8'hFF, 1'b0, "ones byte");
        check("ones cnt", 40'(bus.dbg_cnt), 40'd0);
        check("ones empty", 40'(bus.axiov), 40'd0);

        // codeNum 0..3 then flush
        send(16'd1, 1'b1, 1'b0, "v1");
        send(16'd2, 1'b1, 1'b0, "v2");
        send(16'd3, 1'b1, 1'b0, "v3");
        check("v3 no byte", 40'(bus.axiov), 40'd0);
        send(16'd4, 1'b1, 1'b0, "v4");
        check("v4 latency", 40'(bus.axiov), 40'd1);
        pop(8'hA6, 1'b0, "seq b0");
        send(16'd0, 1'b0, 1'b1, "seq flush");
        pop(8'h48, 1'b1, "seq b1");
        check("seq drained", 40'(bus.axiov), 40'd0);
        check("seq state", 40'(bus.dbg_state), 40'd0);

        // Longest codeword, separate flush
        send(16'hFFFF, 1'b1, 1'b0, "long");
        check("long cnt", 40'(bus.dbg_cnt), 40'd31);
        check("long blocked", 40'(bus.axiir), 40'd0);
        pop(8'h00, 1'b0, "long b0");
        check("long blocked2", 40'(bus.axiir), 40'd0);
        pop(8'h01, 1'b0, "long b1");
        pop(8'hFF, 1'b0, "long b2");
        send(16'd0, 1'b0, 1'b1, "long flush");
        check("flush blocks", 40'(bus.axiir), 40'd0);
        pop(8'hFF, 1'b1, "long b3");
        check("long reopen", 40'(bus.axiir), 40'd1);

        // Codeword and flush in the same cycle
        send(16'd2, 1'b1, 1'b1, "cwfl");
        pop(8'h50, 1'b1, "cwfl byte");

        // Maximum occupancy: 7 pending + 31 + stop
        for (int i = 0; i < 7; i++) send(16'h0001, 1'b1, 1'b0, "pre7");
        send(16'hFFFF, 1'b1, 1'b1, "max");
        check("max cnt", 40'(bus.dbg_cnt), 40'd40);
        pop(8'hFE, 1'b0, "max b0");
        pop(8'h00, 1'b0, "max b1");
        pop(8'h03, 1'b0, "max b2");
        pop(8'hFF, 1'b0, "max b3");
        pop(8'hFE, 1'b1, "max b4");

        // Empty flush and zero codeword
        send(16'd0, 1'b0, 1'b1, "empty flush");
        pop(8'h80, 1'b1, "empty byte");
        send(16'd0, 1'b1, 1'b0, "zero");
        check("zero err", 40'(bus.err), 40'd1);
        check("zero cnt", 40'(bus.dbg_cnt), 40'd0);
        check("zero no out", 40'(bus.axiov), 40'd0);
        @(negedge clk);
        check("zero err pulse", 40'(bus.err), 40'd0);

        // Downstream stall on a last byte
        for (int i = 0; i < 8; i++) send(16'h0001, 1'b1, 1'b0, "st ones");
        pop(8'hFF, 1'b0, "st b0");
        send(16'd0, 1'b0, 1'b1, "st flush");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall valid", 40'(bus.axiov), 40'd1);
            check("stall data", 40'(bus.axiod), 40'h80);
            check("stall last", 40'(bus.axiol), 40'd1);
        end
        pop(8'h80, 1'b1, "st b1");
        check("st no dup", 40'(bus.axiov), 40'd0);

        // Reset mid-drain discards everything
        send(16'hFFFF, 1'b1, 1'b0, "mid");
        pop(8'h00, 1'b0, "mid b0");
        rst = 1'b0;
        #1;
        check("mid axiov", 40'(bus.axiov), 40'd0);
        check("mid axiod", 40'(bus.axiod), 40'h00);
        check("mid axiol", 40'(bus.axiol), 40'd0);
        check("mid cnt", 40'(bus.dbg_cnt), 40'd0);
        check("mid axiir", 40'(bus.axiir), 40'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        send(16'd1, 1'b1, 1'b0, "r v1");
        send(16'd2, 1'b1, 1'b0, "r v2");
        send(16'd3, 1'b1, 1'b0, "r v3");
        send(16'd4, 1'b1, 1'b0, "r v4");
        pop(8'hA6, 1'b0, "r b0");
        send(16'd0, 1'b0, 1'b1, "r flush");
        pop(8'h48, 1'b1, "r b1");
        check("r drained", 40'(bus.axiov), 40'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
